game_sequencer: RTL and testbench

Top-level game controller for the runner game. It derives the game-rate tick from the pixel clock and sequences the game through idle, run, crash and game-over states. It turns the player button into one-cycle jump requests, keeps score, ramps obstacle speed and chooses each next obstacle's height. The obstacle/player datapath and renderer consume its outputs and return collision and obstacle-wrap events.

---
 rtl/game_sequencer.sv | 142 ++++++++++++++
 tb/tb_game_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Runner-game controller: game tick prescaler, IDLE/RUN/CRASH/OVER sequencing, jump, score, speed, obstacle height.
// Optional best-score tracking is built when GAME_SEQUENCER_HISCORE_EN is defined.
module game_sequencer #(
  parameter int unsigned TICK_DIV   = 2500000,
  parameter int unsigned CRASH_HOLD = 40,
  parameter int unsigned SPEED_STEP = 10,
  parameter int unsigned MAX_SPEED  = 4,
  parameter int unsigned SCORE_W    = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic               collide,
  input  logic               obstacle_wrap,
  output logic               tick,
  output logic               jump_req,
  output logic [2:0]         speed,
  output logic               obstacle_high,
  output logic               pause,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_CRASH = 2'b10;
  localparam logic [1:0] S_OVER  = 2'b11;

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned HW = $clog2(CRASH_HOLD + 1);
  localparam int unsigned SW = $clog2(SPEED_STEP + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(CRASH_HOLD - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(SPEED_STEP - 1);
  localparam logic [2:0]    SPEED_MAX  = 3'(MAX_SPEED);

  logic          sel_s1, sel_s2, sel_d, sel_rise;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] step_cnt;
  logic [7:0]    lfsr;
  logic [1:0]    state_next;
  logic          presc_last, run, start, crash_go, wrap_ok, hold_done, lfsr_fb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_s1   <= 1'b0;
      sel_s2   <= 1'b0;
      sel_d    <= 1'b0;
      sel_rise <= 1'b0;
    end else begin
      sel_s1   <= sel;
      sel_s2   <= sel_s1;
      sel_d    <= sel_s2;
      sel_rise <= sel_s2 & ~sel_d;
    end
  end

  // collide has priority over both obstacle_wrap and sel_rise while running
  always_comb begin
    presc_last = (presc == PRESC_LAST);
    run        = (state == S_RUN);
    start      = sel_rise && (state == S_IDLE || state == S_OVER);
    crash_go   = run && collide;
    wrap_ok    = run && !collide && obstacle_wrap;
    hold_done  = (state == S_CRASH) && presc_last && (hold_cnt == HOLD_LAST);
    lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    pause      = (state != S_RUN);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_OVER: if (sel_rise) state_next = S_RUN;
      S_RUN:          if (collide) state_next = S_CRASH;
      S_CRASH:        if (hold_done) state_next = S_OVER;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      presc    <= '0;
      hold_cnt <= '0;
      tick     <= 1'b0;
      jump_req <= 1'b0;
    end else begin
      state    <= state_next;
      tick     <= run && !collide && presc_last;
      jump_req <= run && !collide && sel_rise;
      if (start || !(run || state == S_CRASH))
        presc <= '0;
      else
        presc <= presc_last ? '0 : presc + 1'b1;
      if (crash_go)
        hold_cnt <= '0;
      else if (state == S_CRASH && presc_last)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // LFSR and obstacle_high survive game restarts; only rst reseeds them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score         <= '0;
      speed         <= 3'd1;
      step_cnt      <= '0;
      lfsr          <= 8'hA5;
      obstacle_high <= 1'b0;
    end else if (start) begin
      score    <= '0;
      speed    <= 3'd1;
      step_cnt <= '0;
    end else if (wrap_ok) begin
      if (score != '1)
        score <= score + 1'b1;
      lfsr          <= {lfsr[6:0], lfsr_fb};
      obstacle_high <= lfsr_fb;
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        if (speed != SPEED_MAX)
          speed <= speed + 3'd1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

`ifdef GAME_SEQUENCER_HISCORE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hi_score <= '0;
    else if (crash_go && score > hi_score)
      hi_score <= score;
  end
`else
  assign hi_score = '0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer (small prescaler/hold/speed parameters).
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst, sel, collide, obstacle_wrap;
  logic        tick, jump_req, obstacle_high, pause;
  logic [2:0]  speed;
  logic [1:0]  state;
  logic [10:0] score, hi_score;

  int checks = 0;
  int errors = 0;

`ifdef GAME_SEQUENCER_HISCORE_EN
  localparam int HI5 = 5;
`else
  localparam int HI5 = 0;
`endif

  game_sequencer #(
    .TICK_DIV(4), .CRASH_HOLD(3), .SPEED_STEP(2), .MAX_SPEED(3), .SCORE_W(11)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .collide(collide), .obstacle_wrap(obstacle_wrap),
    .tick(tick), .jump_req(jump_req), .speed(speed), .obstacle_high(obstacle_high),
    .pause(pause), .state(state), .score(score), .hi_score(hi_score)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sel sampled high on two edges; caller is just after the second one
  task automatic press_sel();
    sel = 1'b1;
    step();
    step();
    sel = 1'b0;
  endtask

  task automatic wrap_once();
    obstacle_wrap = 1'b1;
    step();
    obstacle_wrap = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_score"}, 32'(score), 0);
    chk({tag, "_hi"}, 32'(hi_score), 0);
    chk({tag, "_speed"}, 32'(speed), 1);
    chk({tag, "_pause"}, 32'(pause), 1);
    chk({tag, "_high"}, 32'(obstacle_high), 0);
    chk({tag, "_tick"}, 32'(tick), 0);
    chk({tag, "_jump"}, 32'(jump_req), 0);
  endtask

  logic [2:0] spd_tab [7] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
  logic       hi_tab  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int seen;
    rst = 1'b0; sel = 1'b0; collide = 1'b0; obstacle_wrap = 1'b0;
    #12;
    reset_checks("por");
    rst = 1'b1;

    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick || jump_req) seen++;
    end
    chk("idle_no_tick", 32'(seen), 0);
    reset_checks("idle");

    press_sel();
    step();
    chk("start_wait_state", 32'(state), 0);
    step();
    chk("start_state", 32'(state), 1);
    chk("start_pause", 32'(pause), 0);
    chk("start_jump", 32'(jump_req), 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("tick_%0d", i), 32'(tick), 32'(i % 4 == 0));
    end

    press_sel();
    step();
    chk("jump_early", 32'(jump_req), 0);
    step();
    chk("jump_pulse", 32'(jump_req), 1);
    step();
    chk("jump_end", 32'(jump_req), 0);

    for (int i = 0; i < 7; i++) begin
      wrap_once();
      chk($sformatf("g1_score_%0d", i), 32'(score), 32'(i + 1));
      chk($sformatf("g1_speed_%0d", i), 32'(speed), 32'(spd_tab[i]));
      chk($sformatf("g1_high_%0d", i), 32'(obstacle_high), 32'(hi_tab[i]));
    end

    #3 rst = 1'b0;
    #1 reset_checks("rst_g1");
    step();
    rst = 1'b1;
    step();

    press_sel();
    step();
    step();
    chk("g2_state", 32'(state), 1);
    for (int i = 0; i < 5; i++) begin
      wrap_once();
      chk($sformatf("g2_high_%0d", i), 32'(obstacle_high), 32'(hi_tab[i]));
    end
    chk("g2_score", 32'(score), 5);

    seen = 0;
    for (int i = 0; i < 8 && seen == 0; i++) begin
      step();
      if (tick) seen = 1;
    end
    chk("g2_tick_found", 32'(seen), 1);
    step();
    step();
    step();
    collide = 1'b1;
    obstacle_wrap = 1'b1;
    step();
    collide = 1'b0;
    obstacle_wrap = 1'b0;
    chk("crash_state", 32'(state), 2);
    chk("crash_tick", 32'(tick), 0);
    chk("crash_score", 32'(score), 5);
    chk("crash_pause", 32'(pause), 1);
    chk("crash_hi", 32'(hi_score), 32'(HI5));
    for (int i = 0; i < 11; i++) step();
    chk("crash_hold", 32'(state), 2);
    step();
    chk("over_state", 32'(state), 3);

    wrap_once();
    chk("over_wrap_ignored", 32'(score), 5);

    press_sel();
    step();
    step();
    chk("g3_state", 32'(state), 1);
    chk("g3_score", 32'(score), 0);
    chk("g3_speed", 32'(speed), 1);
    chk("g3_hi", 32'(hi_score), 32'(HI5));
    for (int i = 5; i < 8; i++) begin
      wrap_once();
      chk($sformatf("g3_high_%0d", i), 32'(obstacle_high), 32'(hi_tab[i]));
    end
    chk("g3_score3", 32'(score), 3);
    chk("g3_speed2", 32'(speed), 2);

    press_sel();
    step();
    collide = 1'b1;
    step();
    collide = 1'b0;
    chk("sel_collide_state", 32'(state), 2);
    chk("sel_collide_jump", 32'(jump_req), 0);
    for (int i = 0; i < 20 && state != 2'b11; i++) step();
    chk("g3_over", 32'(state), 3);
    chk("g3_hi_kept", 32'(hi_score), 32'(HI5));

    press_sel();
    step();
    step();
    for (int i = 0; i < 4; i++) wrap_once();
    chk("g4_score", 32'(score), 4);
    #3 rst = 1'b0;
    #1 reset_checks("rst_g4");
    step();
    rst = 1'b1;
    step();
    press_sel();
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      wrap_once();
      chk($sformatf("reseed_high_%0d", i), 32'(obstacle_high), 32'(hi_tab[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
